// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds CHUNK bits per cycle; optional subtract via SERIAL_CHUNK_ADDER_SUB_EN
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_a, r_b, r_sum;
  logic                   r_c, r_a_msb, r_b_msb;
  logic                   w_sub;
  logic                   w_last;
  logic [CHUNK:0]         w_chunk;
  logic [WIDTH+CHUNK-1:0] w_cat;
  logic [WIDTH-1:0]       w_sum_next;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif
  // Low chunk of the shifting operands plus running carry; the new chunk enters the sum from the top
  always_comb begin
    w_chunk    = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + (CHUNK+1)'(r_c);
    w_cat      = {w_chunk[CHUNK-1:0], r_sum};
    w_sum_next = WIDTH'(w_cat >> CHUNK);
    w_last     = (r_cnt == CW'(N - 1));
  end
  // Carry into the MSB is recovered from the MSB sum bit and the latched operand MSBs
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    sum       = out_valid ? r_sum : '0;
    cout      = out_valid & r_c;
    ovf       = out_valid & (r_a_msb ^ r_b_msb ^ r_sum[WIDTH-1] ^ r_c);
  end
  // Accept operands, ripple one chunk per RUN cycle, hold the result until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_a     <= a;
        r_b     <= w_sub ? ~b : b;
        r_c     <= w_sub ? 1'b1 : cin;
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= w_sub ? ~b[WIDTH-1] : b[WIDTH-1];
        r_cnt   <= '0;
        r_state <= RUN;
      end
    end else if (r_state == RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_sum   <= w_sum_next;
      r_c     <= w_chunk[CHUNK];
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      r_state <= w_last ? DONE : RUN;
    end else begin
      if (out_ready) r_state <= IDLE;
    end
  end
endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be a multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b, cin present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry into bit 0.
REQ-010 SHALL have port out_valid  output  1  sum, cout, ovf valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result, a+b+cin modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf  output  1  signed overflow, carry into MSB XOR carry out of MSB.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-017 SHALL accept operands on a rising edge where in_valid && in_ready, latching a, b, cin, clearing the chunk counter, and entering RUN.
REQ-018 In RUN, SHALL add chunk i (bits i*CHUNK+CHUNK-1 : i*CHUNK) plus the registered carry at accept edge + 1 + i, for i = 0..N-1, storing the chunk sum and the new carry.
REQ-019 SHALL enter DONE on the edge processing chunk N-1, so out_valid rises exactly N cycles after the accept edge.
REQ-020 SHALL hold sum, cout, ovf stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-021 SHALL ignore in_valid outside IDLE; no second operand pair is accepted until the result is consumed.
REQ-022 SHALL, when out_ready is high on the edge entering IDLE with in_valid high, not accept new operands on that same edge (acceptance requires in_ready already high).
REQ-023 SHALL handle the chunk counter wrap from N-1 by exiting RUN; the counter SHALL never index beyond N-1.
REQ-024 SHALL zero sum, cout, ovf outputs while not in DONE.

Reset
REQ-025 SHALL, on rst high, immediately force state IDLE, counter 0, carry 0, and all internal registers 0, independent of clk.
REQ-026 SHALL drive in_ready=1 and out_valid=0, sum=0, cout=0, ovf=0 during and after reset.
REQ-027 SHALL discard any operation in RUN or DONE when reset is asserted mid-operation; no result is produced for it.

Configuration
REQ-028 SHALL, with macro SERIAL_CHUNK_ADDER_SUB_EN defined, add port sub  input  1, sampled at accept; sub=1 computes a - b by latching ~b and forcing the carry-in to 1, ignoring cin.
REQ-029 SHALL, without SERIAL_CHUNK_ADDER_SUB_EN, have no sub port and perform addition only; cycle timing is identical in both builds.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-030 SHALL test a=0x0000, b=0x0000, cin=0 -> out_valid 4 cycles after accept, sum=0x0000, cout=0, ovf=0.
REQ-031 SHALL test a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (full carry ripple across all chunks).
REQ-032 SHALL test a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; and a=0x6A5C, b=0x1234, cin=1 -> sum=0x7C91, cout=0, ovf=0.
REQ-033 SHALL test backpressure: out_ready held low 3 cycles in DONE -> sum, cout, ovf, out_valid stable; in_ready stays 0; in_valid pulses ignored.
REQ-034 SHALL test rst pulse 2 cycles after accept -> out_valid never asserts, in_ready=1 immediately, next operation a=0x0003, b=0x0004 -> sum=0x0007.
REQ-035 SHALL test (SUB_EN build) a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
